// File: rtl/tog_rx_mem.sv
// N x DEPTH register file for the domain-B receive FIFO.
// One synchronous write port, one asynchronous read port, contents not reset.
module tog_rx_mem #(
    parameter int unsigned N     = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clkB,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [N-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [N-1:0]  rdata
);

    logic [N-1:0] mem [DEPTH];

    always_ff @(posedge clkB) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tog_rx_fifo.sv
// Domain-B receiver for the toggle synchronizer: captures the data word one
// cycle after each transfer pulse into a show-ahead FIFO with a valid/ready output.
module tog_rx_fifo #(
    parameter int unsigned N     = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clkB,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          pulse_in,
    input  logic [N-1:0]  data_in,
    output logic [N-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW:0]   level,
    output logic          overflow,
    input  logic          clr_ovf
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (AW != $clog2(DEPTH))) begin : g_bad_cfg
        $error("tog_rx_fifo: DEPTH must be a power of two >= 2 and AW = log2(DEPTH)");
    end

    logic          pend;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;
    logic          push;
    logic          drop;
    logic          full;
    logic [N-1:0]  rd_word;

    // Full with a simultaneous pop still accepts the pending word.
    always_comb begin
        pop  = out_valid & out_ready;
        full = (level == FULL_LVL);
        push = pend & (~full | pop);
        drop = pend & full & ~pop;
    end

    assign out_valid = (level != '0);
    assign out_data  = out_valid ? rd_word : '0;

    // pend delays capture by one cycle because the synchronizer registers data on the pulse.
    always_ff @(posedge clkB) begin
        if (!rst_n) begin
            pend     <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            pend <= pulse_in & ena;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    tog_rx_mem #(
        .N     (N),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clkB  (clkB),
        .we    (push & rst_n),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (rd_word)
    );

endmodule

// File: tb/tb_tog_rx_fifo.sv
// Scoreboard bench for tog_rx_fifo: a queue model tracks captured words,
// popped words are compared against the queue head.
module tb_tog_rx_fifo;

    localparam int unsigned N     = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;

    logic          clkB = 1'b0;
    logic          rst_n;
    logic          ena;
    logic          pulse_in;
    logic [N-1:0]  data_in;
    logic [N-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW:0]   level;
    logic          overflow;
    logic          clr_ovf;

    int n_checks = 0;
    int n_errors = 0;

    logic [N-1:0] sb_q [$];
    logic         pend_m;
    logic         ovf_m;

    always #5 clkB = ~clkB;

    tog_rx_fifo #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
        .clkB      (clkB),
        .rst_n     (rst_n),
        .ena       (ena),
        .pulse_in  (pulse_in),
        .data_in   (data_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock: predict the edge from current inputs, then check outputs.
    task automatic tick();
        logic         pop_m;
        logic         full_m;
        logic         drop_m;
        logic [N-1:0] w;
        if (!rst_n) begin
            sb_q.delete();
            pend_m = 1'b0;
            ovf_m  = 1'b0;
        end else begin
            pop_m  = (sb_q.size() != 0) && out_ready;
            full_m = (sb_q.size() == DEPTH);
            drop_m = pend_m && full_m && !pop_m;
            if (pop_m) begin
                w = sb_q.pop_front();
                chk("pop_data", 32'(out_data), 32'(w));
            end
            if (pend_m && !drop_m) begin
                sb_q.push_back(data_in);
            end
            if (drop_m) begin
                ovf_m = 1'b1;
            end else if (clr_ovf) begin
                ovf_m = 1'b0;
            end
            pend_m = pulse_in & ena;
        end
        @(posedge clkB);
        #1;
        chk("level", 32'(level), 32'(sb_q.size()));
        chk("valid", 32'(out_valid), 32'(sb_q.size() != 0));
        chk("head", 32'(out_data), (sb_q.size() != 0) ? 32'(sb_q[0]) : 32'h0);
        chk("ovf", 32'(overflow), 32'(ovf_m));
    endtask

    task automatic drive(input logic p, input logic [N-1:0] d, input logic e,
                         input logic r, input logic c);
        pulse_in  = p;
        data_in   = d;
        ena       = e;
        out_ready = r;
        clr_ovf   = c;
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    // Back-to-back pulses carrying base+1 .. base+cnt, no consumer.
    task automatic burst(input int cnt, input logic [N-1:0] base);
        for (int i = 0; i <= cnt; i++) begin
            drive(i < cnt, (i == 0) ? 8'h00 : base + N'(i), 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic drain(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
        end
    endtask

    initial begin
        pend_m = 1'b0;
        ovf_m  = 1'b0;
        pulse_in = 1'b0; data_in = '0; ena = 1'b1; out_ready = 1'b0; clr_ovf = 1'b0;

        // Reset then idle with out_ready high.
        do_reset();
        for (int i = 0; i < 10; i++) drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
        chk("idle_level", 32'(level), 32'h0);

        // Single pulse, then one pop.
        drive(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 8'hA5, 1'b1, 1'b0, 1'b0);
        chk("single_head", 32'(out_data), 32'hA5);
        chk("single_valid", 32'(out_valid), 32'h1);
        drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("single_empty", 32'(level), 32'h0);

        // Six pulses into a 4-deep FIFO: two drops.
        burst(6, 8'h00);
        chk("ovf_level", 32'(level), 32'h4);
        chk("ovf_flag", 32'(overflow), 32'h1);
        chk("ovf_head", 32'(out_data), 32'h01);
        drain(5);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
        chk("ovf_cleared", 32'(overflow), 32'h0);

        // Full plus pulse with a pop in the push cycle.
        burst(4, 8'h10);
        drive(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 8'h15, 1'b1, 1'b1, 1'b0);
        chk("fullpop_level", 32'(level), 32'h4);
        chk("fullpop_ovf", 32'(overflow), 32'h0);
        chk("fullpop_head", 32'(out_data), 32'h12);
        drain(5);

        // ena low blocks detection; a pend already set still pushes.
        drive(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
        chk("ena_blk", 32'(level), 32'h0);
        drive(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 8'h3D, 1'b0, 1'b0, 1'b0);
        chk("ena_late", 32'(out_data), 32'h3D);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        // Reset with level 3 and a pending capture.
        burst(3, 8'h20);
        drive(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        drive(1'b0, 8'h77, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        chk("rst_level", 32'(level), 32'h0);
        drive(1'b0, 8'h78, 1'b1, 1'b0, 1'b0);
        chk("rst_nolate", 32'(level), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);

        // Drop coinciding with clr_ovf keeps overflow set.
        burst(4, 8'h30);
        drive(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 8'h35, 1'b1, 1'b0, 1'b1);
        chk("clr_vs_drop", 32'(overflow), 32'h1);
        drain(5);

        // Random traffic against the scoreboard.
        begin
            logic         p_prev;
            logic [N-1:0] d_next;
            p_prev = 1'b0;
            for (int i = 0; i < 300; i++) begin
                d_next = N'($urandom);
                drive(1'($urandom_range(0, 1)), p_prev ? d_next : 8'h00,
                      ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 7) == 0));
                p_prev = pulse_in & ena;
            end
        end
        drain(6);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
